// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: size codes, FSM states, counter width.
// No ports; imported by dmem_lane_steer and dmem_responder.
`timescale 1ns/1ps
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response channel between core (master) and responder (slave).
// req_*: valid/ready request with we/addr/size/wdata; rsp_*: valid/ready response with rdata/err.
`timescale 1ns/1ps
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_steer.sv
// Byte-lane steering: byte enables, lane-shifted store data, right-aligned load extract.
// Ports: addr_lo/size/wdata/rword in; be/wdata_sh/rdata_ext/misalign out. Macro: DMEM_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module dmem_lane_steer
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [1:0]  off;
    logic [31:0] rsh;

    // Offset is always forced to natural alignment; when trapping is
    // enabled a misaligned access is flagged as an error anyway.
    always_comb begin
        off = 2'b00;
        be  = 4'b0000;
        unique case (size)
            SZ_BYTE: begin
                off = addr_lo;
                be  = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                off = {addr_lo[1], 1'b0};
                be  = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                off = 2'b00;
                be  = 4'b1111;
            end
            default: begin
                off = 2'b00;
                be  = 4'b0000;
            end
        endcase
    end

    assign wdata_sh = wdata << {off, 3'b000};
    assign rsh      = rword >> {off, 3'b000};

    always_comb begin
        rdata_ext = 32'h0;
        unique case (size)
            SZ_BYTE: rdata_ext = {24'h0, rsh[7:0]};
            SZ_HALF: rdata_ext = {16'h0, rsh[15:0]};
            SZ_WORD: rdata_ext = rsh;
            default: rdata_ext = 32'h0;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((size == SZ_HALF) && addr_lo[0]) ||
                      ((size == SZ_WORD) && (addr_lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory target with configurable read/write latency and error flagging.
// Ports: clk, rst (async active-low), bus (dmem_if.slave). Macro: DMEM_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LAT      = 2,
    parameter int WR_LAT      = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] RD_L = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_L = CNT_W'(WR_LAT);

    logic [31:0] mem [DEPTH_WORDS];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [AW-1:0]    idx;
    logic             in_range;
    logic             size_bad;
    logic             misalign;
    logic             err;
    logic             accept;
    logic             wr_en;
    logic [CNT_W-1:0] lat;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      rdata_ext;

    assign idx      = bus.req_addr[AW+1:2];
    assign in_range = {2'b00, bus.req_addr[31:2]} < DEPTH_WORDS;
    assign size_bad = bus.req_size == 2'b11;
    assign err      = !in_range || size_bad || misalign;
    assign accept   = bus.req_valid && bus.req_ready;
    assign wr_en    = accept && bus.req_we && !err && rst;
    assign lat      = bus.req_we ? WR_L : RD_L;
    assign rword    = in_range ? mem[idx] : 32'h0;

    dmem_lane_steer u_steer (
        .addr_lo   (bus.req_addr[1:0]),
        .size      (bus.req_size),
        .wdata     (bus.req_wdata),
        .rword     (rword),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    // Array is not reset; a store commits on its acceptance edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = (!bus.req_we && !err) ? rdata_ext : 32'h0;
                    err_d   = err;
                    cnt_d   = lat - 1'b1;
                    state_d = (lat == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a scoreboard of expected responses.
// Drives dmem_if as master; expected rdata/err/latency queued at each request.
`timescale 1ns/1ps
module tb_dmem_responder;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (256),
        .RD_LAT      (2),
        .WR_LAT      (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [31:0] erd, input logic eerr,
                        input int elat, input int stall);
        exp_t e;
        int   n;
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = elat;
        sbq.push_back(e);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        e = sbq.pop_front();
        check("latency", 32'(n), 32'(e.lat));
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_size  = 2'b00;
                bus.req_wdata = 32'h000000FF;
            end
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_rdata", bus.rsp_rdata, e.rdata);
            check("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("rdata_clear", bus.rsp_rdata, 32'h0);
    endtask

    initial begin
        int seen;
        tests = 0;
        fails = 0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_size  = 2'b00;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load dropped by a reset pulse while waiting.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_size  = 2'b10;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("wait_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen++;
        end
        check("dropped_no_rsp", 32'(seen), 32'd0);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Word store/load with latency check.
        xact(1'b1, 32'h10, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0);
        xact(1'b0, 32'h10, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

        // Byte store into an existing word.
        xact(1'b1, 32'h10, 2'b10, 32'h11223344, 32'h0, 1'b0, 1, 0);
        xact(1'b1, 32'h13, 2'b00, 32'h0000005A, 32'h0, 1'b0, 1, 0);
        xact(1'b0, 32'h10, 2'b10, 32'h0, 32'h5A223344, 1'b0, 2, 0);
        xact(1'b0, 32'h13, 2'b00, 32'h0, 32'h0000005A, 1'b0, 2, 0);
        xact(1'b0, 32'h12, 2'b01, 32'h0, 32'h00005A22, 1'b0, 2, 0);

        // Backpressure with an ignored request pulse aimed at 0x30.
        xact(1'b1, 32'h30, 2'b00, 32'h000000AB, 32'h0, 1'b0, 1, 0);
        bus.req_addr = 32'h30;
        xact(1'b0, 32'h30, 2'b00, 32'h0, 32'h000000AB, 1'b0, 2, 5);
        xact(1'b0, 32'h30, 2'b10, 32'h0, 32'h000000AB, 1'b0, 2, 0);

        // Range and size errors; word 0 shares low index bits with 0x400.
        xact(1'b1, 32'h0, 2'b10, 32'h01234567, 32'h0, 1'b0, 1, 0);
        xact(1'b1, 32'h3FC, 2'b10, 32'h01020304, 32'h0, 1'b0, 1, 0);
        xact(1'b0, 32'h3FC, 2'b10, 32'h0, 32'h01020304, 1'b0, 2, 0);
        xact(1'b1, 32'h400, 2'b10, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
        xact(1'b0, 32'h400, 2'b10, 32'h0, 32'h0, 1'b1, 2, 0);
        xact(1'b0, 32'h0, 2'b10, 32'h0, 32'h01234567, 1'b0, 2, 0);
        xact(1'b1, 32'h10, 2'b11, 32'h99999999, 32'h0, 1'b1, 1, 0);
        xact(1'b0, 32'h10, 2'b11, 32'h0, 32'h0, 1'b1, 2, 0);
        xact(1'b0, 32'h10, 2'b10, 32'h0, 32'h5A223344, 1'b0, 2, 0);

        // Misaligned halfword store.
        xact(1'b1, 32'h20, 2'b10, 32'h11111111, 32'h0, 1'b0, 1, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        xact(1'b1, 32'h21, 2'b01, 32'h0000BEEF, 32'h0, 1'b1, 1, 0);
        xact(1'b0, 32'h20, 2'b10, 32'h0, 32'h11111111, 1'b0, 2, 0);
        xact(1'b0, 32'h23, 2'b01, 32'h0, 32'h0, 1'b1, 2, 0);
`else
        xact(1'b1, 32'h21, 2'b01, 32'h0000BEEF, 32'h0, 1'b0, 1, 0);
        xact(1'b0, 32'h20, 2'b10, 32'h0, 32'h1111BEEF, 1'b0, 2, 0);
        xact(1'b0, 32'h23, 2'b01, 32'h0, 32'h00001111, 1'b0, 2, 0);
        xact(1'b0, 32'h21, 2'b00, 32'h0, 32'h000000BE, 1'b0, 2, 0);
`endif

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
